up_down_counter_param: RTL and testbench

//   Parametrised synchronous up/down counter; generalises the fixed 4-bit counter.

---
 rtl/up_down_counter_param.sv | 70 +++++++
 tb/tb_up_down_counter_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - parametrised up/down counter with load, runtime terminal value and wrap pulse
// Usable as an event/position counter or as a cascadable prescaler (wrap_pulse feeds the next stage's en).
module up_down_counter_param #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO      = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up) begin
                // count may sit above a freshly lowered max_val; >= catches that too
                if (count < max_val) begin
                    count_nxt = count + ONE;
                end else if (SATURATE) begin
                    count_nxt = max_val;
                end else begin
                    count_nxt = ZERO;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count != ZERO) begin
                    count_nxt = count - ONE;
                end else if (SATURATE) begin
                    count_nxt = ZERO;
                end else begin
                    count_nxt = max_val;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= RST_COUNT;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

    assign at_max  = (count == max_val);
    assign at_zero = (count == ZERO);

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - directed vector bench for up_down_counter_param (wrap and saturate builds)
module tb_up_down_counter_param;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0, max_val = 4'd9;
    logic [3:0] count;
    logic       at_max, at_zero, wrap_pulse;

    logic       s_en = 1'b0, s_up = 1'b0, s_load = 1'b0;
    logic [3:0] s_load_val = '0, s_max_val = 4'd5;
    logic [3:0] s_count;
    logic       s_at_max, s_at_zero, s_wrap_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    up_down_counter_param #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .count(count),
        .at_max(at_max), .at_zero(at_zero), .wrap_pulse(wrap_pulse)
    );

    up_down_counter_param #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .en(s_en), .up(s_up), .load(s_load),
        .load_val(s_load_val), .max_val(s_max_val), .count(s_count),
        .at_max(s_at_max), .at_zero(s_at_zero), .wrap_pulse(s_wrap_pulse)
    );

    typedef struct {
        logic       ld;
        logic       e;
        logic       u;
        logic [3:0] lv;
        logic [3:0] mv;
        logic [3:0] c;
        logic       w;
        logic       am;
        logic       az;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic ld, input logic e, input logic u,
                                input logic [3:0] lv, input logic [3:0] mv,
                                input logic [3:0] c, input logic w,
                                input logic am, input logic az);
        vec_t v;
        v = '{ld, e, u, lv, mv, c, w, am, az};
        vecs.push_back(v);
    endfunction

    task automatic s_step(input string name, input logic [3:0] c, input logic w);
        tick();
        check({name, " count"}, s_count, c);
        check({name, " wrap"}, s_wrap_pulse, w);
    endtask

    initial begin
        // up wrap, max 9: 1..9 then 0 with a single-cycle pulse
        for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 9, 4'(i), 0, i == 9, 0);
        add(0, 1, 1, 0, 9, 0, 1, 0, 1);
        add(0, 1, 1, 0, 9, 1, 0, 0, 0);
        // load priority and clamping
        add(1, 1, 1, 12, 9, 9, 0, 1, 0);
        add(1, 1, 0, 3, 9, 3, 0, 0, 0);
        add(0, 0, 1, 0, 9, 3, 0, 0, 0);
        // down wrap with max 9 and max 15
        add(1, 0, 0, 1, 9, 1, 0, 0, 0);
        add(0, 1, 0, 0, 9, 0, 0, 0, 1);
        add(0, 1, 0, 0, 9, 9, 1, 1, 0);
        add(1, 0, 0, 1, 15, 1, 0, 0, 0);
        add(0, 1, 0, 0, 15, 0, 0, 0, 1);
        add(0, 1, 0, 0, 15, 15, 1, 1, 0);
        add(1, 1, 0, 5, 15, 5, 0, 0, 0);
        // runtime max drop: up wraps immediately, down walks back into range
        add(1, 0, 0, 8, 15, 8, 0, 0, 0);
        add(0, 1, 1, 0, 4, 0, 1, 0, 1);
        add(1, 0, 0, 8, 15, 8, 0, 0, 0);
        add(0, 1, 0, 0, 4, 7, 0, 0, 0);
        add(0, 1, 0, 0, 4, 6, 0, 0, 0);
        add(0, 1, 0, 0, 4, 5, 0, 0, 0);
        add(0, 1, 0, 0, 4, 4, 0, 1, 0);
        add(0, 1, 0, 0, 4, 3, 0, 0, 0);
        // max_val = 0: wrap every cycle in both directions
        add(0, 1, 1, 0, 0, 0, 1, 1, 1);
        add(0, 1, 1, 0, 0, 0, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // reset state
        tick();
        tick();
        check("rst count", count, 0);
        check("rst at_zero", at_zero, 1);
        check("rst wrap", wrap_pulse, 0);
        check("rst at_max", at_max, 0);
        reset_n = 1'b1;
        tick();
        check("idle count", count, 0);

        // async reset mid-cycle from count 7, overriding a pending load
        load = 1'b1; load_val = 4'd7;
        tick();
        check("pre-rst count", count, 7);
        en = 1'b1; load_val = 4'd5;
        #2 reset_n = 1'b0;
        #1;
        check("async rst count", count, 0);
        check("async rst at_zero", at_zero, 1);
        check("async rst wrap", wrap_pulse, 0);
        tick();
        check("rst over load", count, 0);
        reset_n = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        check("post-rst count", count, 0);

        foreach (vecs[i]) begin
            load = vecs[i].ld; en = vecs[i].e; up = vecs[i].u;
            load_val = vecs[i].lv; max_val = vecs[i].mv;
            tick();
            check($sformatf("v%0d count", i), count, vecs[i].c);
            check($sformatf("v%0d wrap", i), wrap_pulse, vecs[i].w);
            check($sformatf("v%0d at_max", i), at_max, vecs[i].am);
            check($sformatf("v%0d at_zero", i), at_zero, vecs[i].az);
        end
        en = 1'b0; load = 1'b0;

        // saturate build: clamp at max and at zero without pulses
        s_load = 1'b1; s_load_val = 4'd3; s_max_val = 4'd5;
        s_step("sat load", 3, 0);
        s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
        s_step("sat up1", 4, 0);
        s_step("sat up2", 5, 0);
        check("sat at_max", s_at_max, 1);
        s_step("sat up3", 5, 0);
        s_step("sat up4", 5, 0);
        s_load = 1'b1; s_load_val = 4'd1;
        s_step("sat load1", 1, 0);
        s_load = 1'b0; s_up = 1'b0;
        s_step("sat dn1", 0, 0);
        s_step("sat dn2", 0, 0);
        check("sat at_zero", s_at_zero, 1);
        s_load = 1'b1; s_load_val = 4'd9; s_max_val = 4'd15;
        s_step("sat load9", 9, 0);
        s_load = 1'b0; s_up = 1'b1; s_max_val = 4'd5;
        s_step("sat clamp", 5, 0);
        s_max_val = 4'd0;
        s_step("sat max0", 0, 0);
        s_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
